// File: rtl/alu_seq_if.sv
// Operand/result bundle between the CCU register-file read ports, alu_seq and write-back.
interface alu_seq_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [3:0]       n;
  logic             out_valid;
  logic [WIDTH-1:0] r;
  logic [3:0]       cc;
  logic             write_en;
  logic             err;

  modport master (
    output in_valid, a, b, n,
    input  in_ready, out_valid, r, cc, write_en, err
  );

  modport slave (
    input  in_valid, a, b, n,
    output in_ready, out_valid, r, cc, write_en, err
  );
endinterface

// File: rtl/alu_seq.sv
// Registered CCU ALU: single-cycle ops plus iterative shift-add multiply and restoring divide.
module alu_seq #(
  parameter  int WIDTH = 8,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO     = {WIDTH{1'b0}};

  state_t           state_r, state_s;
  logic [CNT_W-1:0] cnt_r;
  logic             is_div_r;
  logic [WIDTH-1:0] p_r, q_r, s_r;
  logic [WIDTH-1:0] r_r;
  logic [3:0]       cc_r;
  logic             err_r, out_valid_r, write_en_r;

  logic             in_ready_s, accept_s, iter_op_s;
  logic [WIDTH-1:0] single_r_s;
  logic [3:0]       single_cc_s;
  logic             single_err_s;
  logic [WIDTH:0]   div_sh_s, div_diff_s;
  logic [WIDTH-1:0] iter_p_s, iter_q_s, iter_s_s, fin_r_s;
  logic [3:0]       fin_cc_s;
  logic             div0_s;

  assign accept_s  = bus.in_valid && in_ready_s;
  assign iter_op_s = (bus.n == 4'd8) || (bus.n == 4'd9);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_r <= IDLE;
    else        state_r <= state_s;
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (accept_s && iter_op_s) state_s = BUSY; else state_s = IDLE;
      BUSY:    if (cnt_r == CNT_ONE) state_s = IDLE; else state_s = BUSY;
      default: state_s = IDLE;
    endcase
  end

  // FSM outputs: readiness depends on state only
  always_comb begin
    in_ready_s = 1'b0;
    case (state_r)
      IDLE:    in_ready_s = 1'b1;
      BUSY:    in_ready_s = 1'b0;
      default: in_ready_s = 1'b0;
    endcase
  end

  // Single-cycle result and condition code; max/min flag which operand won in cc[3:2]
  always_comb begin
    single_r_s   = ZERO;
    single_cc_s  = 4'b0000;
    single_err_s = 1'b0;
    case (bus.n)
      4'd0: begin single_r_s = bus.a + bus.b;                   single_cc_s[0] = 1'b1; end
      4'd1: begin single_r_s = bus.a - bus.b;                   single_cc_s[0] = 1'b1; end
      4'd2: begin single_r_s = {bus.a[WIDTH-2:0], 1'b0};        single_cc_s[0] = 1'b1; end
      4'd3: begin single_r_s = {1'b0, bus.a[WIDTH-1:1]};        single_cc_s[0] = 1'b1; end
      4'd4: single_r_s = bus.a;
      4'd5: single_r_s = bus.b;
      4'd6: begin
        if (bus.a >= bus.b) begin single_r_s = bus.a; single_cc_s[2] = 1'b1; end
        else                begin single_r_s = bus.b; single_cc_s[3] = 1'b1; end
      end
      4'd7: begin
        if (bus.a < bus.b) begin single_r_s = bus.a; single_cc_s[3] = 1'b1; end
        else               begin single_r_s = bus.b; single_cc_s[2] = 1'b1; end
      end
      4'd8, 4'd9: single_r_s = ZERO;
      default: single_err_s = 1'b1;
    endcase
    single_cc_s[1] = single_cc_s[0] && (single_r_s == ZERO);
  end

  // One iteration: mul uses p=acc, q=multiplier, s=multiplicand; div uses p=rem, q=quotient, s=divisor
  always_comb begin
    div_sh_s   = {p_r, q_r[WIDTH-1]};
    div_diff_s = div_sh_s - {1'b0, s_r};
    iter_p_s   = p_r;
    iter_q_s   = q_r;
    iter_s_s   = s_r;
    if (is_div_r) begin
      if (!div_diff_s[WIDTH]) begin
        iter_p_s = div_diff_s[WIDTH-1:0];
        iter_q_s = {q_r[WIDTH-2:0], 1'b1};
      end else begin
        iter_p_s = div_sh_s[WIDTH-1:0];
        iter_q_s = {q_r[WIDTH-2:0], 1'b0};
      end
    end else begin
      iter_p_s = p_r + (q_r[0] ? s_r : ZERO);
      iter_q_s = {1'b0, q_r[WIDTH-1:1]};
      iter_s_s = {s_r[WIDTH-2:0], 1'b0};
    end
    // A zero divisor never borrows, so the quotient naturally saturates to all ones
    fin_r_s  = is_div_r ? iter_q_s : iter_p_s;
    div0_s   = is_div_r && (s_r == ZERO);
    fin_cc_s = {2'b00, !div0_s && (fin_r_s == ZERO), 1'b1};
  end

  // Operand capture, iteration registers and registered results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r       <= {CNT_W{1'b0}};
      is_div_r    <= 1'b0;
      p_r         <= ZERO;
      q_r         <= ZERO;
      s_r         <= ZERO;
      r_r         <= ZERO;
      cc_r        <= 4'b0000;
      err_r       <= 1'b0;
      out_valid_r <= 1'b0;
      write_en_r  <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      write_en_r  <= 1'b0;
      if (state_r == IDLE) begin
        if (accept_s) begin
          if (iter_op_s) begin
            is_div_r <= bus.n[0];
            cnt_r    <= CNT_INIT;
            p_r      <= ZERO;
            q_r      <= bus.n[0] ? bus.a : bus.b;
            s_r      <= bus.n[0] ? bus.b : bus.a;
          end else begin
            r_r         <= single_r_s;
            cc_r        <= single_cc_s;
            err_r       <= single_err_s;
            out_valid_r <= 1'b1;
            write_en_r  <= !single_err_s;
          end
        end
      end else begin
        p_r   <= iter_p_s;
        q_r   <= iter_q_s;
        s_r   <= iter_s_s;
        cnt_r <= cnt_r - CNT_ONE;
        if (cnt_r == CNT_ONE) begin
          r_r         <= fin_r_s;
          cc_r        <= fin_cc_s;
          err_r       <= div0_s;
          out_valid_r <= 1'b1;
          write_en_r  <= !div0_s;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.r         = r_r;
  assign bus.cc        = cc_r;
  assign bus.err       = err_r;
  assign bus.write_en  = write_en_r;
endmodule

// File: tb/tb_alu_seq.sv
// Directed self-checking bench for alu_seq at WIDTH=8 and WIDTH=16.
module tb_alu_seq;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(8))  bus8();
  alu_seq_if #(.WIDTH(16)) bus16();

  alu_seq #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
  alu_seq #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));

  // got/exp packing for WIDTH=8: {out_valid, write_en, err, cc, r}
  logic [14:0] got, exp;

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [3:0] n);
    bus8.in_valid = v; bus8.a = a; bus8.b = b; bus8.n = n;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive8(1'b0, 8'h00, 8'h00, 4'h0);
    bus16.in_valid = 1'b0; bus16.a = 16'h0000; bus16.b = 16'h0000; bus16.n = 4'h0;
    rst_n = 1'b0;
    #3;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00})
      begin errors++; $display("FAIL reset: got rdy/ov/we/err/cc/r=%b%b%b%b/%h/%h expected 1000/0/00", bus8.in_ready, bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r); end
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    tick();
  endtask

  task automatic test_add();
    drive8(1'b1, 8'hFF, 8'h01, 4'd0);
    tick(); drive8(1'b0, 8'h00, 8'h00, 4'd0);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0011, 8'h00};
    checks++; if (got !== exp) begin errors++; $display("FAIL add_wrap: got %h expected %h", got, exp); end
    tick();
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b0, 1'b0, 1'b0, 4'b0011, 8'h00};
    checks++; if (got !== exp) begin errors++; $display("FAIL add_pulse_hold: got %h expected %h", got, exp); end
  endtask

  task automatic test_back_to_back();
    drive8(1'b1, 8'd5, 8'd9, 4'd6);
    tick(); drive8(1'b1, 8'd5, 8'd9, 4'd7);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b1000, 8'd9};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_max: got %h expected %h", got, exp); end
    tick(); drive8(1'b1, 8'd3, 8'd5, 4'd1);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b1000, 8'd5};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_min: got %h expected %h", got, exp); end
    tick(); drive8(1'b0, 8'd0, 8'd0, 4'd0);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0001, 8'hFE};
    checks++; if (got !== exp) begin errors++; $display("FAIL b2b_sub: got %h expected %h", got, exp); end
  endtask

  task automatic test_equal_and_shift();
    drive8(1'b1, 8'd7, 8'd7, 4'd6);
    tick(); drive8(1'b1, 8'd7, 8'd7, 4'd7);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0100, 8'd7};
    checks++; if (got !== exp) begin errors++; $display("FAIL max_equal: got %h expected %h", got, exp); end
    tick(); drive8(1'b1, 8'h80, 8'h00, 4'd2);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0100, 8'd7};
    checks++; if (got !== exp) begin errors++; $display("FAIL min_equal: got %h expected %h", got, exp); end
    tick(); drive8(1'b1, 8'h81, 8'h00, 4'd3);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0011, 8'h00};
    checks++; if (got !== exp) begin errors++; $display("FAIL shl_out: got %h expected %h", got, exp); end
    tick(); drive8(1'b0, 8'h00, 8'h00, 4'd0);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0001, 8'h40};
    checks++; if (got !== exp) begin errors++; $display("FAIL shr_logical: got %h expected %h", got, exp); end
  endtask

  task automatic test_mul();
    drive8(1'b1, 8'd13, 8'd11, 4'd8);
    tick();
    // Different operands held valid while busy must be ignored, then accepted right after
    drive8(1'b1, 8'd2, 8'd3, 4'd0);
    checks++; if (bus8.in_ready !== 1'b0) begin errors++; $display("FAIL mul_ready_low: got %b expected 0", bus8.in_ready); end
    for (int i = 1; i < 8; i++) begin
      tick();
      checks++;
      if ({bus8.in_ready, bus8.out_valid} !== 2'b00) begin errors++; $display("FAIL mul_busy_%0d: got rdy/ov=%b%b expected 00", i, bus8.in_ready, bus8.out_valid); end
    end
    tick();
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0001, 8'd143};
    checks++; if (got !== exp || bus8.in_ready !== 1'b1) begin errors++; $display("FAIL mul_13x11: got %h rdy=%b expected %h rdy=1", got, bus8.in_ready, exp); end
    tick(); drive8(1'b0, 8'd0, 8'd0, 4'd0);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0001, 8'd5};
    checks++; if (got !== exp) begin errors++; $display("FAIL mul_next_accept: got %h expected %h", got, exp); end
  endtask

  task automatic test_div();
    int lat;
    drive8(1'b1, 8'd200, 8'd7, 4'd9);
    tick(); drive8(1'b0, 8'd0, 8'd0, 4'd0);
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    checks++; if (lat != 8) begin errors++; $display("FAIL div_latency: got %0d edges expected 8", lat); end
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0001, 8'd28};
    checks++; if (got !== exp) begin errors++; $display("FAIL div_200_7: got %h expected %h", got, exp); end
    drive8(1'b1, 8'd5, 8'd0, 4'd9);
    tick(); drive8(1'b0, 8'd0, 8'd0, 4'd0);
    lat = 0;
    while (bus8.out_valid !== 1'b1 && lat < 40) begin tick(); lat++; end
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b0, 1'b1, 4'b0001, 8'hFF};
    checks++; if (got !== exp || lat != 8) begin errors++; $display("FAIL div_by_zero: got %h lat=%0d expected %h lat=8", got, lat, exp); end
  endtask

  task automatic test_illegal();
    drive8(1'b1, 8'd3, 8'd4, 4'hC);
    tick(); drive8(1'b1, 8'h00, 8'h5A, 4'd5);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b0, 1'b1, 4'b0000, 8'h00};
    checks++; if (got !== exp) begin errors++; $display("FAIL illegal_op: got %h expected %h", got, exp); end
    tick(); drive8(1'b0, 8'h00, 8'h00, 4'd0);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0000, 8'h5A};
    checks++; if (got !== exp) begin errors++; $display("FAIL passb: got %h expected %h", got, exp); end
  endtask

  task automatic test_reset_mid_busy();
    int seen;
    drive8(1'b1, 8'd13, 8'd11, 4'd8);
    tick(); drive8(1'b0, 8'd0, 8'd0, 4'd0);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bus8.in_ready, bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r} !== {1'b1, 1'b0, 1'b0, 1'b0, 4'h0, 8'h00})
      begin errors++; $display("FAIL reset_mid_busy: got rdy/ov/we/err/cc/r=%b%b%b%b/%h/%h expected 1000/0/00", bus8.in_ready, bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r); end
    @(negedge clk); rst_n = 1'b1;
    drive8(1'b1, 8'd1, 8'd2, 4'd0);
    tick(); drive8(1'b0, 8'd0, 8'd0, 4'd0);
    got = {bus8.out_valid, bus8.write_en, bus8.err, bus8.cc, bus8.r}; exp = {1'b1, 1'b1, 1'b0, 4'b0001, 8'd3};
    checks++; if (got !== exp) begin errors++; $display("FAIL first_accept_after_reset: got %h expected %h", got, exp); end
    seen = 0;
    repeat (12) begin tick(); if (bus8.out_valid === 1'b1) seen++; end
    checks++; if (seen != 0) begin errors++; $display("FAIL stale_out_valid: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_wide_mul();
    int lat;
    logic [22:0] got16, exp16;
    bus16.in_valid = 1'b1; bus16.a = 16'd300; bus16.b = 16'd300; bus16.n = 4'd8;
    tick(); bus16.in_valid = 1'b0;
    lat = 0;
    while (bus16.out_valid !== 1'b1 && lat < 60) begin tick(); lat++; end
    checks++; if (lat != 16) begin errors++; $display("FAIL wide_latency: got %0d edges expected 16", lat); end
    got16 = {bus16.out_valid, bus16.write_en, bus16.err, bus16.cc, bus16.r}; exp16 = {1'b1, 1'b1, 1'b0, 4'b0001, 16'h5F90};
    checks++; if (got16 !== exp16) begin errors++; $display("FAIL wide_mul_300x300: got %h expected %h", got16, exp16); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_equal_and_shift();
    test_mul();
    test_div();
    test_illegal();
    test_reset_mid_busy();
    test_wide_mul();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised, registered successor to the 8-bit combinational CCU ALU. It adds a valid/ready operand handshake, registered results, and iterative shift-add multiply and restoring divide. It also adds divide-by-zero and illegal-opcode error reporting. It sits between the CCU register-file read ports and the write-back stage, and drives the same 4-bit condition code and write-enable semantics as the existing ALU.

## Interface
Parameters:
- WIDTH, 8, operand/result width (>= 2)
- CNT_W, $clog2(WIDTH+1), iteration counter width (derived, not overridden)

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  block can accept an operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- n  input  4  opcode
- out_valid  output  1  one-cycle pulse: r/cc/err updated this cycle
- r  output  WIDTH  result, held until next out_valid
- cc  output  4  condition code, held with r
- write_en  output  1  write-back strobe, = out_valid && !err
- err  output  1  illegal opcode or divide by zero, held with r

Reset state (rst_n=0, asynchronous): IDLE, in_ready=1, out_valid=0, r=0, cc=0, write_en=0, err=0.

## Operation
- Accept: on a rising edge where in_valid && in_ready, capture a, b, n.
- Single-cycle ops:
  - 0 add: r=a+b, mod 2^WIDTH
  - 1 sub: r=a-b, mod 2^WIDTH
  - 2 shl: r=a<<1
  - 3 shr: r=a>>1, logical
  - 4 passA
  - 5 passB
  - 6 max: r=a if a>=b, else b (unsigned)
  - 7 min: r=a if a<b, else b (unsigned)
- Iterative ops:
  - 8 mul: low WIDTH bits of a*b, shift-add, one bit per cycle, LSB first
  - 9 div: unsigned quotient a/b, restoring, one bit per cycle, MSB first
- cc[0]=1 for ops 0,1,2,3,8,9; 0 otherwise.
- cc[1]=1 when cc[0]=1 and r==0.
- cc[2]=1 when ops 6/7 select a... except it follows the existing ALU rule: max sets cc[2] when a>=b, else cc[3]. Min sets cc[3] when a<b, else cc[2]. cc[3:2]=0 for all other ops.
- Opcodes 10-15 are illegal: single-cycle, r=0, cc=0, err=1, write_en=0.
- Divide by zero (op 9, b=0): full WIDTH iterations still run. r=all ones, cc[0]=1, cc[1]=0, err=1, write_en=0.
- State machine:
  - IDLE: in_ready=1. Accepting an iterative op loads the accumulator/remainder and sets cnt=WIDTH, then goes to BUSY. Accepting any other op registers the result and stays in IDLE.
  - BUSY: in_ready=0. One iteration per edge, cnt decrements. The edge with cnt==1 registers the result, pulses out_valid and returns to IDLE.
- in_valid and operands are ignored while BUSY. The source must hold them until in_ready.

## Timing
- Accept at edge k, single-cycle op: out_valid=1 in the cycle after edge k. Back-to-back single-cycle ops sustain one result per cycle.
- Accept at edge k, iterative op:
  - in_ready=0 from edge k to edge k+WIDTH.
  - out_valid=1 in the cycle after edge k+WIDTH; in_ready returns to 1 in that same cycle.
  - The earliest next accept is edge k+WIDTH+1, i.e. latency WIDTH+1 cycles.
- in_ready is a function of state only, with no combinational path from in_valid.
- out_valid and write_en are pulses. r, cc and err change only together with out_valid.
- Reset asserted mid-BUSY: the operation is aborted immediately, all outputs go to their reset values, and no out_valid is issued. First accept is possible at the first edge after rst_n deasserts.

## Test plan
- Reset, then add a=8'hFF, b=8'h01 (WIDTH=8) -> next cycle: r=8'h00, cc=4'b0011, write_en=1, err=0.
- Back-to-back single ops: max(5,9), then min(5,9), then sub(3,5) on consecutive edges.
  - Results on consecutive cycles: r=9, cc=4'b1000; then r=5, cc=4'b1000; then r=8'hFE, cc=4'b0001.
- mul a=13, b=11 -> in_ready low for 8 cycles, then r=143, cc=4'b0001, out_valid 9 cycles after accept. Also hold in_valid with different operands during BUSY -> ignored.
- div a=200, b=7 -> r=28, cc=4'b0001. Then div a=5, b=0 -> r=8'hFF, err=1, write_en=0, cc=4'b0001.
- Opcode 4'hC -> r=0, cc=0, err=1, write_en=0, out_valid pulse. Follow with passB b=8'h5A -> r=8'h5A, cc=0, err=0.
- Assert rst_n=0 on cycle 3 of a mul -> all outputs at reset values, no stale out_valid after release. WIDTH=16 regression: mul 300*300 -> r=16'h5F90 (low 16 bits of 90000), latency 17.
